tensor_core_operand_stager: RTL

- Stages operands for `small_tensor_core` and collects its results.
- Upstream side: collects a 32-byte serial stream into two 4x4 signed 8-bit operand matrices, then drives write-enable and start to the core and waits for `is_done_with_calculation`.
- Downstream side: captures the 4x4 result into a local buffer and streams it back out as 16 bytes over a valid/ready handshake.
- Sits between the byte-wide host/command interface and the tensor core.

---
 rtl/tensor_core_operand_stager.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/tensor_core_operand_stager.sv
// Operand stager for small_tensor_core: gathers two 4x4 byte matrices from a serial
// stream, sequences the core, then drains the 4x4 result as 16 handshaked bytes.
module tensor_core_operand_stager #(
    parameter int DATA_WIDTH   = 8,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic                            clock_in,
    input  logic                            reset_in,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [3:0][3:0][DATA_WIDTH-1:0] tensor_core_input1,
    output logic [3:0][3:0][DATA_WIDTH-1:0] tensor_core_input2,
    output logic                            tensor_core_register_file_write_enable,
    output logic                            should_start_tensor_core,
    input  logic [3:0][3:0][DATA_WIDTH-1:0] tensor_core_output,
    input  logic                            is_done_with_calculation,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            error
);
    localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(DONE_TIMEOUT - 1);

    localparam logic [2:0] ST_LOAD      = 3'd0;
    localparam logic [2:0] ST_WRITE     = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_DRAIN     = 3'd4;

    logic [2:0]                  state_r;
    logic [4:0]                  load_idx_r;
    logic [3:0]                  drain_idx_r;
    logic [TW-1:0]               tmo_cnt_r;
    logic [15:0][DATA_WIDTH-1:0] result_r;
    logic                        in_accept_s;
    logic                        out_accept_s;
    logic [3:0]                  drain_nxt_s;

    // Handshake qualifiers and next drain position
    always_comb begin
        in_accept_s  = (state_r == ST_LOAD) && in_valid && in_ready;
        out_accept_s = (state_r == ST_DRAIN) && out_valid && out_ready;
        drain_nxt_s  = drain_idx_r + 4'd1;
    end

    // Sequencer: operand load, core handshake, done watchdog and result drain
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_r                                <= ST_LOAD;
            load_idx_r                             <= 5'd0;
            drain_idx_r                            <= 4'd0;
            tmo_cnt_r                              <= '0;
            result_r                               <= '0;
            tensor_core_input1                     <= '0;
            tensor_core_input2                     <= '0;
            in_ready                               <= 1'b1;
            out_valid                              <= 1'b0;
            out_data                               <= '0;
            tensor_core_register_file_write_enable <= 1'b0;
            should_start_tensor_core               <= 1'b0;
            busy                                   <= 1'b0;
            error                                  <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (in_accept_s) begin
                        // index bit 4 selects B, low bits give row-major position
                        if (load_idx_r[4]) begin
                            tensor_core_input2[load_idx_r[3:2]][load_idx_r[1:0]] <= in_data;
                        end else begin
                            tensor_core_input1[load_idx_r[3:2]][load_idx_r[1:0]] <= in_data;
                        end
                        load_idx_r <= load_idx_r + 5'd1;
                        if (load_idx_r == 5'd31) begin
                            state_r                                <= ST_WRITE;
                            in_ready                               <= 1'b0;
                            busy                                   <= 1'b1;
                            tensor_core_register_file_write_enable <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    tensor_core_register_file_write_enable <= 1'b0;
                    should_start_tensor_core               <= 1'b1;
                    state_r                                <= ST_START;
                end
                ST_START: begin
                    should_start_tensor_core <= 1'b0;
                    tmo_cnt_r                <= '0;
                    state_r                  <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (is_done_with_calculation) begin
                        result_r  <= tensor_core_output;
                        out_data  <= tensor_core_output[0][0];
                        out_valid <= 1'b1;
                        state_r   <= ST_DRAIN;
                    end else if (tmo_cnt_r == TIMEOUT_LAST) begin
                        // the consumer still gets a full (zeroed) result frame
                        result_r  <= '0;
                        out_data  <= '0;
                        out_valid <= 1'b1;
                        error     <= 1'b1;
                        state_r   <= ST_DRAIN;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (out_accept_s) begin
                        if (drain_idx_r == 4'd15) begin
                            drain_idx_r <= 4'd0;
                            out_valid   <= 1'b0;
                            out_data    <= '0;
                            in_ready    <= 1'b1;
                            busy        <= 1'b0;
                            state_r     <= ST_LOAD;
                        end else begin
                            drain_idx_r <= drain_nxt_s;
                            out_data    <= result_r[drain_nxt_s];
                        end
                    end
                end
                default: begin
                    state_r                                <= ST_LOAD;
                    load_idx_r                             <= 5'd0;
                    drain_idx_r                            <= 4'd0;
                    in_ready                               <= 1'b1;
                    out_valid                              <= 1'b0;
                    busy                                   <= 1'b0;
                    tensor_core_register_file_write_enable <= 1'b0;
                    should_start_tensor_core               <= 1'b0;
                end
            endcase
        end
    end
endmodule
